// File: rtl/atm_controller.sv
// ============================================================================
// Module   : atm_controller
// Brief    : ATM session FSM owning the account database (IDs, PINs, balances)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module atm_controller #(
    parameter int N_ACCT    = 4,
    parameter int ID_W      = 4,
    parameter int PIN_W     = 4,
    parameter int BAL_W     = 8,
    parameter int INIT_BAL  = 100,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic             lang_sel,
    input  logic             lang_valid,
    input  logic [ID_W-1:0]  acct_id,
    input  logic [PIN_W-1:0] pin,
    input  logic             pin_valid,
    input  logic [2:0]       op,
    input  logic             op_valid,
    input  logic [BAL_W-1:0] amount,
    input  logic [ID_W-1:0]  dest_id,
    input  logic [PIN_W-1:0] new_pin,
    input  logic             exit,
    output logic [BAL_W-1:0] balance,
    output logic             done,
    output logic [2:0]       err,
    output logic             language,
    output logic             card_eject,
    output logic [2:0]       state
);

    localparam int IDX_W  = (N_ACCT > 1) ? $clog2(N_ACCT) : 1;
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] E_OK     = 3'd0;
    localparam logic [2:0] E_BADPIN = 3'd1;
    localparam logic [2:0] E_LOCKED = 3'd2;
    localparam logic [2:0] E_INSUF  = 3'd3;
    localparam logic [2:0] E_OVF    = 3'd4;
    localparam logic [2:0] E_BADDST = 3'd5;
    localparam logic [2:0] E_BADOP  = 3'd6;
    localparam logic [2:0] E_TMO    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LANG  = 3'd1,
        S_PIN   = 3'd2,
        S_MENU  = 3'd3,
        S_EXEC  = 3'd4,
        S_EJECT = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic               done_q, done_d;
    logic [2:0]         err_q, err_d;
    logic               language_q, language_d;
    logic               card_eject_q, card_eject_d;
    logic [FAIL_W-1:0]  fails_q, fails_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [IDX_W-1:0]   sess_q, sess_d;
    logic [2:0]         op_q, op_d;
    logic [BAL_W-1:0]   amt_q, amt_d;
    logic [ID_W-1:0]    dst_q, dst_d;
    logic [PIN_W-1:0]   npin_q, npin_d;
    logic [BAL_W-1:0]   bal_q [N_ACCT];
    logic [BAL_W-1:0]   bal_d [N_ACCT];
    logic [PIN_W-1:0]   pin_q [N_ACCT];
    logic [PIN_W-1:0]   pin_d [N_ACCT];
    logic [N_ACCT-1:0]  locked_q, locked_d;

    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_didx;
    logic               w_id_ok;
    logic               w_dst_ok;
    logic               w_abort;
    logic               w_strobe;
    logic               w_counting;
    logic [BAL_W-1:0]   w_self_bal;
    logic [BAL_W-1:0]   w_dst_bal;
    logic [BAL_W:0]     w_self_sum;
    logic [BAL_W:0]     w_dst_sum;

    assign w_idx      = acct_id[IDX_W-1:0];
    assign w_didx     = dst_q[IDX_W-1:0];
    assign w_id_ok    = 32'(acct_id) < 32'(N_ACCT);
    assign w_dst_ok   = (32'(dst_q) < 32'(N_ACCT)) && (32'(dst_q) != 32'(sess_q));
    assign w_abort    = exit || !card_in;
    assign w_strobe   = lang_valid || pin_valid || op_valid;
    assign w_counting = (state_q == S_LANG) || (state_q == S_PIN) || (state_q == S_MENU);
    assign w_self_bal = bal_q[sess_q];
    assign w_dst_bal  = bal_q[w_didx];
    assign w_self_sum = {1'b0, w_self_bal} + {1'b0, amt_q};
    assign w_dst_sum  = {1'b0, w_dst_bal} + {1'b0, amt_q};

    always_comb begin
        state_d      = state_q;
        balance_d    = balance_q;
        done_d       = 1'b0;
        err_d        = err_q;
        language_d   = language_q;
        fails_d      = fails_q;
        sess_d       = sess_q;
        op_d         = op_q;
        amt_d        = amt_q;
        dst_d        = dst_q;
        npin_d       = npin_q;
        bal_d        = bal_q;
        pin_d        = pin_q;
        locked_d     = locked_q;

        case (state_q)
            S_IDLE: begin
                if (card_in) state_d = S_LANG;
            end
            S_LANG: begin
                if (w_abort) begin
                    state_d = S_EJECT;
                end else if (lang_valid) begin
                    language_d = lang_sel;
                    state_d    = S_PIN;
                end else if (tmo_q == TMO_LAST) begin
                    done_d  = 1'b1;
                    err_d   = E_TMO;
                    state_d = S_EJECT;
                end
            end
            S_PIN: begin
                if (w_abort) begin
                    state_d = S_EJECT;
                end else if (pin_valid) begin
                    done_d = 1'b1;
                    if (w_id_ok && locked_q[w_idx]) begin
                        err_d   = E_LOCKED;
                        state_d = S_EJECT;
                    end else if (w_id_ok && (pin_q[w_idx] == pin)) begin
                        err_d     = E_OK;
                        sess_d    = w_idx;
                        fails_d   = '0;
                        balance_d = bal_q[w_idx];
                        state_d   = S_MENU;
                    end else begin
                        err_d   = E_BADPIN;
                        fails_d = fails_q + FAIL_W'(1);
                        if (32'(fails_q) + 32'd1 >= 32'(MAX_TRIES)) begin
                            if (w_id_ok) locked_d[w_idx] = 1'b1;
                            state_d = S_EJECT;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    done_d  = 1'b1;
                    err_d   = E_TMO;
                    state_d = S_EJECT;
                end
            end
            S_MENU: begin
                if (w_abort) begin
                    state_d = S_EJECT;
                end else if (op_valid) begin
                    op_d    = op;
                    amt_d   = amount;
                    dst_d   = dest_id;
                    npin_d  = new_pin;
                    state_d = (op == 3'b000) ? S_EJECT : S_EXEC;
                end else if (tmo_q == TMO_LAST) begin
                    done_d  = 1'b1;
                    err_d   = E_TMO;
                    state_d = S_EJECT;
                end
            end
            S_EXEC: begin
                // The latched op always commits; exit/card removal only redirects the next state.
                done_d = 1'b1;
                err_d  = E_OK;
                case (op_q)
                    3'b001: begin
                        if (w_self_sum[BAL_W]) err_d = E_OVF;
                        else bal_d[sess_q] = w_self_sum[BAL_W-1:0];
                    end
                    3'b010: begin
                        if (amt_q > w_self_bal) err_d = E_INSUF;
                        else bal_d[sess_q] = w_self_bal - amt_q;
                    end
                    3'b011: begin
                        if (!w_dst_ok) begin
                            err_d = E_BADDST;
                        end else if (amt_q > w_self_bal) begin
                            err_d = E_INSUF;
                        end else if (w_dst_sum[BAL_W]) begin
                            err_d = E_OVF;
                        end else begin
                            bal_d[sess_q] = w_self_bal - amt_q;
                            bal_d[w_didx] = w_dst_sum[BAL_W-1:0];
                        end
                    end
                    3'b100:  pin_d[sess_q] = npin_q;
                    3'b101:  err_d = E_OK;
                    default: err_d = E_BADOP;
                endcase
                balance_d = bal_d[sess_q];
                state_d   = w_abort ? S_EJECT : S_MENU;
            end
            S_EJECT: begin
                fails_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        card_eject_d = (state_d == S_EJECT) && (state_q != S_EJECT);

        if (!w_counting || w_strobe || (state_d != state_q)) tmo_d = '0;
        else tmo_d = tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            balance_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= E_OK;
            language_q   <= 1'b0;
            card_eject_q <= 1'b0;
            fails_q      <= '0;
            tmo_q        <= '0;
            sess_q       <= '0;
            op_q         <= '0;
            amt_q        <= '0;
            dst_q        <= '0;
            npin_q       <= '0;
            locked_q     <= '0;
            for (int k = 0; k < N_ACCT; k++) begin
                bal_q[k] <= BAL_W'(INIT_BAL);
                pin_q[k] <= PIN_W'(k);
            end
        end else begin
            state_q      <= state_d;
            balance_q    <= balance_d;
            done_q       <= done_d;
            err_q        <= err_d;
            language_q   <= language_d;
            card_eject_q <= card_eject_d;
            fails_q      <= fails_d;
            tmo_q        <= tmo_d;
            sess_q       <= sess_d;
            op_q         <= op_d;
            amt_q        <= amt_d;
            dst_q        <= dst_d;
            npin_q       <= npin_d;
            locked_q     <= locked_d;
            bal_q        <= bal_d;
            pin_q        <= pin_d;
        end
    end

    assign balance    = balance_q;
    assign done       = done_q;
    assign err        = err_q;
    assign language   = language_q;
    assign card_eject = card_eject_q;
    assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_atm_controller.sv
// ============================================================================
// Module   : tb_atm_controller
// Brief    : Directed + randomized session bench against a transaction-level account model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_atm_controller;

    localparam int N_ACCT    = 4;
    localparam int ID_W      = 4;
    localparam int PIN_W     = 4;
    localparam int BAL_W     = 8;
    localparam int INIT_BAL  = 100;
    localparam int MAX_TRIES = 3;
    localparam int TIMEOUT   = 255;
    localparam int MAXV      = (1 << BAL_W) - 1;

    logic             clk;
    logic             rst;
    logic             card_in;
    logic             lang_sel;
    logic             lang_valid;
    logic [ID_W-1:0]  acct_id;
    logic [PIN_W-1:0] pin;
    logic             pin_valid;
    logic [2:0]       op;
    logic             op_valid;
    logic [BAL_W-1:0] amount;
    logic [ID_W-1:0]  dest_id;
    logic [PIN_W-1:0] new_pin;
    logic             exit;
    logic [BAL_W-1:0] balance;
    logic             done;
    logic [2:0]       err;
    logic             language;
    logic             card_eject;
    logic [2:0]       state;

    atm_controller #(
        .N_ACCT(N_ACCT), .ID_W(ID_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
        .INIT_BAL(INIT_BAL), .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .lang_sel(lang_sel),
        .lang_valid(lang_valid), .acct_id(acct_id), .pin(pin),
        .pin_valid(pin_valid), .op(op), .op_valid(op_valid), .amount(amount),
        .dest_id(dest_id), .new_pin(new_pin), .exit(exit), .balance(balance),
        .done(done), .err(err), .language(language), .card_eject(card_eject),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Account database as the customer sees it
    int m_bal  [N_ACCT];
    int m_pin  [N_ACCT];
    bit m_lock [N_ACCT];
    int m_fails;
    int m_sess;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_ACCT; k++) begin
            m_bal[k]  = INIT_BAL;
            m_pin[k]  = k % (1 << PIN_W);
            m_lock[k] = 1'b0;
        end
        m_fails = 0;
        m_sess  = 0;
    endtask

    task automatic finish_eject(input string tag);
        check_eq({tag, "_state_eject"}, int'(state), 5);
        check_eq({tag, "_card_eject"}, int'(card_eject), 1);
        exit    = 1'b0;
        card_in = 1'b0;
        m_fails = 0;
        tick();
        check_eq({tag, "_state_idle"}, int'(state), 0);
        check_eq({tag, "_eject_pulse_end"}, int'(card_eject), 0);
    endtask

    task automatic start_session(input bit ls);
        card_in = 1'b1;
        tick();
        check_eq("sess_lang_state", int'(state), 1);
        lang_sel   = ls;
        lang_valid = 1'b1;
        tick();
        lang_valid = 1'b0;
        check_eq("sess_pin_state", int'(state), 2);
        check_eq("sess_language", int'(language), int'(ls));
    endtask

    // result: 0 = in MENU, 1 = ejected, 2 = still waiting for PIN
    task automatic enter_pin(input int id, input int p, output int result);
        int e;
        bit ej;
        ej = 1'b0;
        if (id < N_ACCT && m_lock[id]) begin
            e  = 2;
            ej = 1'b1;
        end else if (id < N_ACCT && m_pin[id] == p) begin
            e = 0;
            m_fails = 0;
            m_sess  = id;
        end else begin
            e = 1;
            m_fails++;
            if (m_fails >= MAX_TRIES) begin
                if (id < N_ACCT) m_lock[id] = 1'b1;
                ej = 1'b1;
            end
        end
        acct_id   = ID_W'(id);
        pin       = PIN_W'(p);
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        check_eq("pin_done", int'(done), 1);
        check_eq("pin_err", int'(err), e);
        if (e == 0) begin
            check_eq("pin_balance", int'(balance), m_bal[id]);
            check_eq("pin_state_menu", int'(state), 3);
            result = 0;
        end else if (ej) begin
            finish_eject("pin");
            result = 1;
        end else begin
            check_eq("pin_state_stay", int'(state), 2);
            result = 2;
        end
    endtask

    task automatic model_op(input int o, input int a, input int d, input int np, output int e);
        int s;
        s = m_sess;
        e = 0;
        case (o)
            1: if (m_bal[s] + a > MAXV) e = 4; else m_bal[s] += a;
            2: if (a > m_bal[s]) e = 3; else m_bal[s] -= a;
            3: begin
                if (d >= N_ACCT || d == s) e = 5;
                else if (a > m_bal[s]) e = 3;
                else if (m_bal[d] + a > MAXV) e = 4;
                else begin
                    m_bal[s] -= a;
                    m_bal[d] += a;
                end
            end
            4: m_pin[s] = np;
            5: e = 0;
            default: e = 6;
        endcase
    endtask

    task automatic do_op(input int o, input int a, input int d, input int np, input bit with_exit);
        int e;
        op       = 3'(o);
        amount   = BAL_W'(a);
        dest_id  = ID_W'(d);
        new_pin  = PIN_W'(np);
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        if (o == 0) begin
            finish_eject("op0");
            return;
        end
        check_eq("op_exec_state", int'(state), 4);
        check_eq("op_exec_no_done", int'(done), 0);
        exit = with_exit;
        tick();
        model_op(o, a, d, np, e);
        check_eq("op_done", int'(done), 1);
        check_eq("op_err", int'(err), e);
        check_eq("op_balance", int'(balance), m_bal[m_sess]);
        if (with_exit) finish_eject("op_exit");
        else check_eq("op_state_menu", int'(state), 3);
    endtask

    task automatic exit_sess();
        exit = 1'b1;
        tick();
        finish_eject("exit");
    endtask

    task automatic login(input int id, input int p, output int result);
        start_session(1'($urandom_range(0, 1)));
        enter_pin(id, p, result);
    endtask

    initial begin
        int r;
        int cyc;
        rst = 1'b1; card_in = 1'b0; lang_sel = 1'b0; lang_valid = 1'b0;
        acct_id = '0; pin = '0; pin_valid = 1'b0; op = '0; op_valid = 1'b0;
        amount = '0; dest_id = '0; new_pin = '0; exit = 1'b0;
        model_reset();
        tick(); tick();
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_balance", int'(balance), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_err", int'(err), 0);
        check_eq("rst_language", int'(language), 0);
        check_eq("rst_card_eject", int'(card_eject), 0);
        rst = 1'b0;
        tick();

        // Account 2: query, withdraw, overdraw
        login(2, 2, r);
        do_op(5, 0, 0, 0, 1'b0);
        check_eq("plan_bal100", int'(balance), 100);
        do_op(2, 30, 0, 0, 1'b0);
        check_eq("plan_bal70", int'(balance), 70);
        do_op(2, 80, 0, 0, 1'b0);
        check_eq("plan_insuf", int'(err), 3);
        exit_sess();

        // Account 1 lockout
        start_session(1'b0);
        for (int t = 0; t < MAX_TRIES; t++) enter_pin(1, 7, r);
        check_eq("lockout_ejected", r, 1);
        login(1, 1, r);
        check_eq("locked_err", int'(err), 2);

        // Transfer and destination overflow / bad destination
        login(0, 0, r);
        do_op(3, 50, 3, 0, 1'b0);
        check_eq("plan_bal50", int'(balance), 50);
        do_op(3, 10, 0, 0, 1'b0);
        check_eq("plan_baddst", int'(err), 5);
        do_op(0, 0, 0, 0, 1'b0);
        login(3, 3, r);
        check_eq("plan_bal150", int'(balance), 150);
        do_op(1, 200, 0, 0, 1'b0);
        check_eq("plan_ovf", int'(err), 4);

        // Exit wins over a simultaneous MENU strobe; no op executed
        op = 3'b001; amount = 8'd5; op_valid = 1'b1; exit = 1'b1;
        tick();
        op_valid = 1'b0;
        check_eq("exit_wins_no_done", int'(done), 0);
        finish_eject("exit_wins");

        // PIN change, then old PIN rejected and new PIN accepted
        login(2, 2, r);
        do_op(4, 0, 0, 9, 1'b0);
        exit_sess();
        login(2, 2, r);
        check_eq("old_pin_rejected", r, 2);
        enter_pin(2, 9, r);
        check_eq("new_pin_menu", r, 0);

        // Exit during EXEC still commits the deposit
        do_op(1, 11, 0, 0, 1'b1);
        login(2, 9, r);
        check_eq("exit_exec_committed", int'(balance), 81);

        // Inactivity timeout in MENU
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (done !== 1'b1 && cyc < TIMEOUT + 10);
        $display("timeout observed after %0d cycles", cyc);
        check_eq("tmo_window", int'(cyc >= TIMEOUT - 1 && cyc <= TIMEOUT + 1), 1);
        check_eq("tmo_err", int'(err), 7);
        finish_eject("tmo");

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            start_session(1'($urandom_range(0, 1)));
            r = 2;
            for (int t = 0; t < MAX_TRIES + 1 && r == 2; t++) begin
                int id, p;
                id = ($urandom_range(0, 9) < 8) ? $urandom_range(0, N_ACCT - 1)
                                                : $urandom_range(N_ACCT, N_ACCT + 2);
                if (id < N_ACCT && $urandom_range(0, 3) != 0) p = m_pin[id];
                else p = $urandom_range(0, (1 << PIN_W) - 1);
                enter_pin(id, p, r);
            end
            if (r == 2) exit_sess();
            if (r == 0) begin
                int nops;
                nops = $urandom_range(1, 6);
                for (int k = 0; k < nops; k++) begin
                    int amt;
                    amt = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 60) : $urandom_range(0, MAXV);
                    do_op($urandom_range(1, 7), amt, $urandom_range(0, N_ACCT + 1),
                          $urandom_range(0, (1 << PIN_W) - 1), 1'b0);
                end
                if ($urandom_range(0, 1) == 0) do_op(0, 0, 0, 0, 1'b0);
                else exit_sess();
            end
        end

        // Reset in the middle of EXEC restores the whole database
        for (int k = 0; k < N_ACCT; k++) begin
            if (!m_lock[k]) begin
                login(k, m_pin[k], r);
                break;
            end
        end
        if (state == 3'd3) begin
            op = 3'b010; amount = 8'd1; op_valid = 1'b1;
            tick();
            op_valid = 1'b0;
            check_eq("rst_mid_exec_state", int'(state), 4);
        end
        rst = 1'b1;
        #1;
        check_eq("rst_async_state", int'(state), 0);
        check_eq("rst_async_balance", int'(balance), 0);
        check_eq("rst_async_done", int'(done), 0);
        card_in = 1'b0; exit = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        for (int k = 0; k < N_ACCT; k++) begin
            login(k, k, r);
            check_eq("post_rst_bal", int'(balance), INIT_BAL);
            exit_sess();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
